seq_detect_scheduler: RTL and testbench



---
 rtl/seq_detect_scheduler.sv | 153 +++++++++++++++
 tb/tb_seq_detect_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one serial pattern detector between N_REQ requesters.
// Each granted word is shifted MSB-first; overlapping matches are counted and reported.
module seq_detect_scheduler #(
    parameter int unsigned      N_REQ   = 4,
    parameter int unsigned      WORD_W  = 16,
    parameter int unsigned      PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b110011
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*WORD_W-1:0]      req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(N_REQ)-1:0]     res_id,
    output logic                         res_hit,
    output logic [$clog2(WORD_W+1)-1:0]  res_count
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(WORD_W+1);

    if (PAT_W > WORD_W) begin : g_bad_pat_w
        $error("PAT_W must not exceed WORD_W");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [PAT_W-1:0]   window_q, window_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   match_q, match_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic               res_valid_q, res_valid_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic               res_hit_q, res_hit_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    idx;
    logic               found;
    logic [PAT_W-1:0]   window_shift;
    logic               hit_now;
    logic [CNT_W-1:0]   count_inc;

    // Rotating priority: search starts just above the last requester served.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(last_grant_q) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;

    assign window_shift = {window_q[PAT_W-2:0], shift_q[WORD_W-1]};
    assign hit_now      = (32'(bit_cnt_q) + 32'd1 >= PAT_W) && (window_shift == PATTERN);
    assign count_inc    = match_q + CNT_W'(hit_now);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        window_d     = window_q;
        bit_cnt_d    = bit_cnt_q;
        match_d      = match_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        res_hit_d    = res_hit_q;
        res_count_d  = res_count_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    shift_d   = req_data[grant_idx*WORD_W +: WORD_W];
                    id_d      = grant_idx;
                    window_d  = '0;
                    bit_cnt_d = '0;
                    match_d   = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d   = shift_q << 1;
                window_d  = window_shift;
                bit_cnt_d = bit_cnt_q + 1'b1;
                match_d   = count_inc;
                // The final bit's match is folded into the reported count.
                if (bit_cnt_q == CNT_W'(WORD_W-1)) begin
                    res_valid_d = 1'b1;
                    res_id_d    = id_q;
                    res_hit_d   = (count_inc != '0);
                    res_count_d = count_inc;
                    state_d     = REPORT;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    res_valid_d  = 1'b0;
                    last_grant_d = res_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            window_q     <= '0;
            bit_cnt_q    <= '0;
            match_q      <= '0;
            id_q         <= '0;
            last_grant_q <= ID_W'(N_REQ-1);
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_hit_q    <= 1'b0;
            res_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            window_q     <= window_d;
            bit_cnt_q    <= bit_cnt_d;
            match_q      <= match_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_hit_q    <= res_hit_d;
            res_count_q  <= res_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_hit   = res_hit_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: vector table, round-robin, backpressure and
// mid-word reset sequences, with results checked through an expectation queue.
module tb_seq_detect_scheduler;

    localparam int N_REQ  = 4;
    localparam int WORD_W = 16;
    localparam int PAT_W  = 6;
    localparam logic [5:0] PAT = 6'b110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic        res_hit;
    logic [4:0]  res_count;

    typedef struct {
        int          id;
        logic [15:0] word;
        int          hit;
        int          cnt;
    } vec_t;

    typedef struct {
        int id;
        int hit;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    seq_detect_scheduler #(
        .N_REQ  (N_REQ),
        .WORD_W (WORD_W),
        .PAT_W  (PAT_W),
        .PATTERN(PAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_id   (res_id),
        .res_hit  (res_hit),
        .res_count(res_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_count(input logic [15:0] w);
        int c = 0;
        for (int p = 0; p <= WORD_W - PAT_W; p++)
            if (w[WORD_W-1-p -: PAT_W] == PAT) c++;
        return c;
    endfunction

    // Scoreboard: each completed result handshake pops one expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got id %0d, expected no pending result", res_id);
            end else begin
                e = sb.pop_front();
                chk("res_id", int'(res_id), e.id);
                chk("res_hit", int'(res_hit), e.hit);
                chk("res_count", int'(res_count), e.cnt);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic send(input int id, input logic [15:0] w, input int hit, input int cnt);
        int got = 0;
        @(posedge clk); #1;
        req_data[id*WORD_W +: WORD_W] = w;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin got = 1; break; end
        end
        chk("grant_seen", got, 1);
        if (got == 1) begin
            chk("grant_onehot", int'(req_ready), 1 << id);
            @(posedge clk);
            sb.push_back('{id, hit, cnt});
            #1;
        end
        req_valid[id] = 1'b0;
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[8];
        int          n, prev, g, got, c;
        logic [15:0] w;
        logic [15:0] rr_w[4];

        vt[0] = '{0, 16'hCC00, 1, 1};
        vt[1] = '{2, 16'hCCC0, 1, 2};
        vt[2] = '{1, 16'h0033, 1, 1};
        vt[3] = '{3, 16'hFFFF, 0, 0};
        vt[4] = '{0, 16'h3333, 1, 3};
        vt[5] = '{3, 16'hCCCC, 1, 3};
        vt[6] = '{1, 16'h0000, 0, 0};
        vt[7] = '{2, 16'h0CC3, 1, 1};

        rst = 1'b1; req_valid = '1; req_data = '0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_res_hit", int'(res_hit), 0);
        chk("rst_res_count", int'(res_count), 0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Latency: result appears exactly WORD_W edges after acceptance; no grant while busy.
        @(posedge clk); #1;
        req_data[15:0] = 16'hCC00;
        req_valid[0]   = 1'b1;
        @(negedge clk);
        chk("first_grant", int'(req_ready), 1);
        @(posedge clk);
        sb.push_back('{0, 1, 1});
        for (int k = 0; k <= WORD_W; k++) begin
            @(negedge clk);
            chk("latency_valid", int'(res_valid), int'(k == WORD_W));
            if (k < WORD_W) chk("ready_in_shift", int'(req_ready), 0);
        end
        req_valid[0] = 1'b0;
        wait_drain();

        for (int i = 0; i < 8; i++) send(vt[i].id, vt[i].word, vt[i].hit, vt[i].cnt);

        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            c = model_count(w);
            send(int'($urandom_range(0, 3)), w, int'(c != 0), c);
        end

        // Round robin from reset with all requesters valid.
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        rr_w[0] = 16'hCC00; rr_w[1] = 16'h0033; rr_w[2] = 16'hCCC0; rr_w[3] = 16'hFFFF;
        req_data  = {rr_w[3], rr_w[2], rr_w[1], rr_w[0]};
        req_valid = '1;
        n = 0; prev = 0;
        for (int i = 0; i < 300 && n < 6; i++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                chk("rr_onehot", int'($onehot(req_ready)), 1);
                g = 0;
                for (int j = 0; j < 4; j++) if (req_ready[j]) g = j;
                chk("rr_order", g, n % 4);
                if (n > 0) chk("rr_spacing", cyc - prev, WORD_W + 2);
                prev = cyc;
                c = model_count(rr_w[g]);
                sb.push_back('{g, int'(c != 0), c});
                n++;
                if (n == 6) begin
                    @(posedge clk); #1;
                    req_valid = '0;
                end
            end
        end
        chk("rr_grants", n, 6);
        wait_drain();

        // Backpressure on requester 1's result, then next grant rotates to 2.
        @(posedge clk); #1;
        res_ready = 1'b0;
        req_data[31:16] = 16'h3333;
        req_valid[1]    = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[1]) begin got = 1; break; end
        end
        chk("bp_grant", got, 1);
        @(posedge clk);
        sb.push_back('{1, 1, 3});
        #1;
        req_data[47:32] = 16'hCCC0;
        req_data[15:0]  = 16'hCC00;
        req_valid       = 4'b0101;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) begin got = 1; break; end
        end
        chk("bp_valid_seen", got, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_hold_valid", int'(res_valid), 1);
            chk("bp_hold_id", int'(res_id), 1);
            chk("bp_hold_hit", int'(res_hit), 1);
            chk("bp_hold_count", int'(res_count), 3);
            chk("bp_no_grant", int'(req_ready), 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_clear", int'(res_valid), 0);
        chk("bp_id_kept", int'(res_id), 1);
        chk("bp_count_kept", int'(res_count), 3);
        chk("bp_next_grant", int'(req_ready), 4);
        @(posedge clk);
        sb.push_back('{2, 1, 2});
        #1;
        req_valid = '0;
        wait_drain();

        // Asynchronous reset during shift cycle 7 of requester 3's word.
        @(posedge clk); #1;
        req_data[63:48] = 16'hCCCC;
        req_valid[3]    = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[3]) begin got = 1; break; end
        end
        chk("rst_mid_grant", got, 1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        req_valid = '1;
        #1;
        chk("arst_res_valid", int'(res_valid), 0);
        chk("arst_res_id", int'(res_id), 0);
        chk("arst_res_hit", int'(res_hit), 0);
        chk("arst_res_count", int'(res_count), 0);
        chk("arst_req_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", int'(req_ready), 1);
        @(posedge clk);
        sb.push_back('{0, 1, 1});
        #1;
        req_valid = '0;
        wait_drain();

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
